sha_wb_bridge: RTL
==================

Name: sha_wb_bridge

Overview:
Wishbone classic slave adapter between the Caravel user-area bus and the SHA-256 core's simple register port (cs/we/address/write_data/read_data/error).
- Decodes the user window and converts each bus cycle into a single-cycle core strobe.
- Waits the core's fixed read latency, then returns one ack.
- Hosts a small bridge status register with sticky error flags and a digest-done interrupt.

Parameters:
BASE_ADDR, 32'h3000_0000, byte base address of the bridge window
ADDR_MASK, 32'hFFFF_FC00, window match mask (1 KiB window)
READ_LATENCY, 1, cycles from core_cs to valid core_read_data (legal range 0..3)

Ports:
wb_clk_i  in  1  single clock for the bridge and the core register port
wb_rst_i  in  1  synchronous, active-high reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  Wishbone write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  single-cycle acknowledge
wbs_dat_o  out  32  read data, registered
core_cs  out  1  core access strobe, one cycle per transaction
core_we  out  1  core write qualifier, valid with core_cs
core_address  out  8  core word address = wbs_adr_i[9:2]
core_write_data  out  32  core write data
core_read_data  in  32  core read data
core_error  in  1  core access error flag
core_digest_valid  in  1  core digest-valid level
irq  out  1  interrupt = irq_pend & irq_en

Behaviour:
Reset: every output is 0, FSM goes to IDLE, status register clears to 0. Reset asserted mid-transaction drops the transaction with no ack.

Window hit: (wbs_adr_i & ADDR_MASK) == BASE_ADDR.

Status register (STAT):
- Located at word 0xFF (byte offset 0x3FC). It is bridge-local and never forwarded to the core.
- Bit 0 irq_en: read/write.
- Bit 1 irq_pend: write-1-to-clear.
- Bit 2 addr_err, bit 3 sel_err, bit 4 core_err: write-1-to-clear.
- Bits 31:5 read as 0.

FSM states: IDLE, ACCESS, WAIT, ACK, DONE.
- IDLE: on stb & cyc, latch adr, we, dat, sel and classify the request.
  - Out of window: go to ACK with rdata 0 and set addr_err.
  - Write with sel != 4'hF: go to ACK, no core write, set sel_err.
  - STAT access: go to ACK.
  - Any other request: go to ACCESS.
- ACCESS: core_cs = 1 for exactly one cycle, with core_we, core_address and core_write_data valid.
  - Write: go to ACK.
  - Read with READ_LATENCY = 0: capture core_read_data now, go to ACK.
  - Read with READ_LATENCY > 0: go to WAIT.
- WAIT: count READ_LATENCY - 1 further cycles, capture core_read_data on the last one, go to ACK.
- ACK: wbs_ack_o = 1 for one cycle and wbs_dat_o holds the captured data. core_error sampled during ACCESS/WAIT sets core_err. Go to DONE.
- DONE: one dead cycle so the master can drop stb. Go to IDLE.

Latency, with the request first seen in cycle 0:
- Core write: cs in cycle 1, ack in cycle 2.
- Core read: ack in cycle 2 + READ_LATENCY.
- Local or error access: ack in cycle 1.

Abort: if cyc drops before ACK, return to IDLE with no ack. A core write already strobed stays committed.

wbs_dat_o is forced to 0 outside ACK.

Interrupt: a rising edge of core_digest_valid (registered compare) sets irq_pend. If the edge coincides with a W1C of irq_pend, set wins. The same set-wins rule applies to error flags versus their W1C.

Back-to-back requests: a new request is accepted only in IDLE, so there is at most one outstanding transaction.

Decomposition:
- Shared package sha_wb_pkg holds: FSM state enum; STAT word address 8'hFF; STAT bit indices (IRQ_EN=0, IRQ_PEND=1, ADDR_ERR=2, SEL_ERR=3, CORE_ERR=4); default BASE_ADDR and ADDR_MASK.
- One sub-module, sha_wb_stat_reg: STAT storage, W1C/set priority, edge detect and irq output.

Test Plan:
- Write 32'hA5A5_0001 to 0x3000_0010 with sel F -> core_cs one cycle in cycle 1, core_address 8'h04, core_we 1; ack in cycle 2 only.
- Read 0x3000_0020 with core_read_data 32'h1234_5678 and READ_LATENCY 1 -> ack in cycle 3, wbs_dat_o 32'h1234_5678, dat 0 in the next cycle.
- Write to 0x3000_0400 (outside window) -> ack in cycle 1, no core_cs; STAT reads 32'h0000_0004; writing 32'h4 to STAT clears it to 0.
- Write with sel 4'h3 -> no core_cs, ack in cycle 1, STAT bit 3 set.
- Write STAT = 1, then pulse core_digest_valid 0->1 -> irq = 1 next cycle. W1C bit 1 in the same cycle as a second rising edge -> irq stays 1.
- Read in flight, cyc dropped in WAIT -> no ack, FSM back in IDLE, next read completes normally. Reset asserted in ACCESS -> all outputs 0 next cycle.

Source files
------------

// File: rtl/sha_wb_pkg.sv
// Shared definitions for the SHA-256 Wishbone bridge: FSM states, STAT
// register location and bit layout, and the default window decode values.
package sha_wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ACK    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Bridge-local status register word address inside the 1 KiB window
    localparam logic [7:0] STAT_WORD = 8'hFF;

    // STAT bit positions
    localparam int IRQ_EN   = 0;
    localparam int IRQ_PEND = 1;
    localparam int ADDR_ERR = 2;
    localparam int SEL_ERR  = 3;
    localparam int CORE_ERR = 4;
    localparam int STAT_W   = 5;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;
    localparam logic [31:0] DEF_ADDR_MASK = 32'hFFFF_FC00;

endpackage

// File: rtl/sha_wb_stat_reg.sv
// Bridge status register: irq enable, sticky irq-pending and error flags
// with write-1-to-clear, digest-valid rising-edge detect and the irq output.
// A set event in the same cycle as a W1C of the same bit keeps the bit set.
module sha_wb_stat_reg
    import sha_wb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr,
    input  logic [STAT_W-1:0] i_wdata,
    input  logic              i_addr_err_set,
    input  logic              i_sel_err_set,
    input  logic              i_core_err_set,
    input  logic              i_digest_valid,
    output logic [31:0]       o_rdata,
    output logic              o_irq
);

    logic [STAT_W-1:0] r_stat;
    logic              r_dv_q;
    logic              r_irq;
    logic              w_rise;
    logic [STAT_W-1:0] w_set;
    logic [STAT_W-1:0] w_clr;
    logic [STAT_W-1:0] w_nxt;

    // Next STAT value: clear requested W1C bits, then OR in set events
    always_comb begin
        w_rise           = i_digest_valid & ~r_dv_q;
        w_set            = {STAT_W{1'b0}};
        w_set[IRQ_PEND]  = w_rise;
        w_set[ADDR_ERR]  = i_addr_err_set;
        w_set[SEL_ERR]   = i_sel_err_set;
        w_set[CORE_ERR]  = i_core_err_set;
        if (i_wr) begin
            w_clr         = i_wdata;
            w_clr[IRQ_EN] = 1'b0;
        end else begin
            w_clr = {STAT_W{1'b0}};
        end
        w_nxt = (r_stat & ~w_clr) | w_set;
        if (i_wr) begin
            w_nxt[IRQ_EN] = i_wdata[IRQ_EN];
        end else begin
            w_nxt[IRQ_EN] = r_stat[IRQ_EN];
        end
    end

    // STAT storage, digest-valid history and registered irq
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat <= {STAT_W{1'b0}};
            r_dv_q <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_stat <= w_nxt;
            r_dv_q <= i_digest_valid;
            r_irq  <= w_nxt[IRQ_PEND] & w_nxt[IRQ_EN];
        end
    end

    assign o_rdata = {{(32 - STAT_W){1'b0}}, r_stat};
    assign o_irq   = r_irq;

endmodule

// File: rtl/sha_wb_bridge.sv
// Wishbone classic slave bridge to the SHA-256 core register port.
// One bus cycle becomes one core_cs strobe; reads wait READ_LATENCY cycles
// before the single ack. STAT (word 0xFF) is served locally.
module sha_wb_bridge
    import sha_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
    parameter logic [31:0] ADDR_MASK    = DEF_ADDR_MASK,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        core_cs,
    output logic        core_we,
    output logic [7:0]  core_address,
    output logic [31:0] core_write_data,
    input  logic [31:0] core_read_data,
    input  logic        core_error,
    input  logic        core_digest_valid,
    output logic        irq
);

    // WAIT lasts READ_LATENCY cycles; this is the counter value of the last one
    localparam logic [1:0] LAT_LAST = (READ_LATENCY > 32'd0) ? 2'(READ_LATENCY - 32'd1) : 2'd0;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_wait_cnt;
    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_cs;
    logic        r_we;
    logic [7:0]  r_addr;
    logic [31:0] r_wdata;

    logic        w_req;
    logic        w_hit;
    logic        w_is_stat;
    logic        w_sel_bad;
    logic        w_accept;
    logic        w_stat_wr;
    logic        w_addr_err_set;
    logic        w_sel_err_set;
    logic        w_core_err_set;
    logic [31:0] w_stat_rdata;
    logic [31:0] w_ack_data;
    logic        w_irq;

    // Request classification, evaluated on the live bus while IDLE
    assign w_req          = wbs_stb_i & wbs_cyc_i;
    assign w_hit          = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign w_is_stat      = (wbs_adr_i[9:2] == STAT_WORD);
    assign w_sel_bad      = wbs_we_i & (wbs_sel_i != 4'hF);
    assign w_accept       = (r_state == ST_IDLE) & w_req;
    assign w_addr_err_set = w_accept & ~w_hit;
    assign w_sel_err_set  = w_accept & w_hit & w_sel_bad;
    assign w_stat_wr      = w_accept & w_hit & ~w_sel_bad & w_is_stat & wbs_we_i;
    assign w_core_err_set = ((r_state == ST_ACCESS) | (r_state == ST_WAIT)) & core_error;

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; dropping cyc before ACK abandons the transaction
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_req) begin
                    w_next = ST_IDLE;
                end else if (!w_hit || w_sel_bad || w_is_stat) begin
                    w_next = ST_ACK;
                end else begin
                    w_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!wbs_cyc_i) begin
                    w_next = ST_IDLE;
                end else if (r_we || (READ_LATENCY == 32'd0)) begin
                    w_next = ST_ACK;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!wbs_cyc_i) begin
                    w_next = ST_IDLE;
                end else if (r_wait_cnt == LAT_LAST) begin
                    w_next = ST_ACK;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_ACK:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Data to present with the ack when the next state is ACK
    always_comb begin
        w_ack_data = 32'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_hit && !wbs_we_i && w_is_stat) begin
                    w_ack_data = w_stat_rdata;
                end else begin
                    w_ack_data = 32'd0;
                end
            end
            ST_ACCESS: begin
                if (!r_we) begin
                    w_ack_data = core_read_data;
                end else begin
                    w_ack_data = 32'd0;
                end
            end
            ST_WAIT: w_ack_data = core_read_data;
            default: w_ack_data = 32'd0;
        endcase
    end

    // Cycles spent in WAIT
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wait_cnt <= 2'd0;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 2'd1;
        end else begin
            r_wait_cnt <= 2'd0;
        end
    end

    // Registered bus and core outputs, decoded from the upcoming state
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack   <= 1'b0;
            r_dat   <= 32'd0;
            r_cs    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 8'd0;
            r_wdata <= 32'd0;
        end else begin
            r_ack <= (w_next == ST_ACK);
            r_dat <= (w_next == ST_ACK) ? w_ack_data : 32'd0;
            r_cs  <= (w_next == ST_ACCESS);
            if (w_accept) begin
                r_we    <= wbs_we_i;
                r_addr  <= wbs_adr_i[9:2];
                r_wdata <= wbs_dat_i;
            end
        end
    end

    sha_wb_stat_reg u_stat (
        .i_clk          (wb_clk_i),
        .i_rst          (wb_rst_i),
        .i_wr           (w_stat_wr),
        .i_wdata        (wbs_dat_i[STAT_W-1:0]),
        .i_addr_err_set (w_addr_err_set),
        .i_sel_err_set  (w_sel_err_set),
        .i_core_err_set (w_core_err_set),
        .i_digest_valid (core_digest_valid),
        .o_rdata        (w_stat_rdata),
        .o_irq          (w_irq)
    );

    assign wbs_ack_o       = r_ack;
    assign wbs_dat_o       = r_dat;
    assign core_cs         = r_cs;
    assign core_we         = r_we;
    assign core_address    = r_addr;
    assign core_write_data = r_wdata;
    assign irq             = w_irq;

endmodule
